// File: rtl/holo_pkg.sv
// Shared types and helpers for the phase drive path.
// PHASE_DRIVE_DUTY_CTRL_EN adds a per-channel duty field to ch_cfg_t.
package holo_pkg;

  localparam int unsigned DEF_CLK_CNT_W   = 8;
  localparam int unsigned DEF_CLK_CNT_MAX = 256;

  typedef logic [DEF_CLK_CNT_W-1:0] phase_t;

  typedef struct packed {
    logic   en;
    phase_t phase;
`ifdef PHASE_DRIVE_DUTY_CTRL_EN
    phase_t duty;
`endif
  } ch_cfg_t;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } commit_st_e;

  // Modulo subtract; both operands are expected to be below modulus.
  function automatic logic [31:0] phase_diff(input logic [31:0] cnt_v,
                                             input logic [31:0] phase_v,
                                             input logic [31:0] modulus);
    phase_diff = (cnt_v >= phase_v) ? (cnt_v - phase_v) : (cnt_v + modulus - phase_v);
  endfunction

endpackage

// File: rtl/phase_drive_ch.sv
// One transducer channel: active configuration, modulo phase compare and drive flop.
// PHASE_DRIVE_DUTY_CTRL_EN selects a programmable high time instead of half the frame.
module phase_drive_ch
  import holo_pkg::*;
#(
  parameter int unsigned CLK_CNT_W   = DEF_CLK_CNT_W,
  parameter int unsigned CLK_CNT_MAX = DEF_CLK_CNT_MAX
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CLK_CNT_W-1:0] cnt_i,
  input  logic                 apply_i,
  input  logic                 en_i,
  input  logic [CLK_CNT_W-1:0] phase_i,
`ifdef PHASE_DRIVE_DUTY_CTRL_EN
  input  logic [CLK_CNT_W-1:0] duty_i,
`endif
  output logic                 drive_o
);

  localparam int unsigned DW = CLK_CNT_W + 1;
  localparam logic [DW-1:0] MAX_L = DW'(CLK_CNT_MAX);

  logic                 en_q;
  logic [CLK_CNT_W-1:0] phase_q;
  logic [DW-1:0]        high;
  logic [DW-1:0]        diff;
  logic                 drive_d;
  logic                 drive_q;

`ifdef PHASE_DRIVE_DUTY_CTRL_EN
  logic [CLK_CNT_W-1:0] duty_q;
  assign high = {1'b0, duty_q};
`else
  assign high = DW'(CLK_CNT_MAX / 2);
`endif

  always_comb begin
    diff    = DW'(phase_diff(32'(cnt_i), 32'(phase_q), 32'(CLK_CNT_MAX)));
    drive_d = en_q && ({1'b0, cnt_i} < MAX_L) && (diff < high);
  end

  // The drive flop samples the pre-apply configuration on the apply edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      phase_q <= '0;
`ifdef PHASE_DRIVE_DUTY_CTRL_EN
      duty_q  <= CLK_CNT_W'(CLK_CNT_MAX / 2);
`endif
      drive_q <= 1'b0;
    end else begin
      drive_q <= drive_d;
      if (apply_i) begin
        en_q    <= en_i;
        phase_q <= phase_i;
`ifdef PHASE_DRIVE_DUTY_CTRL_EN
        duty_q  <= duty_i;
`endif
      end
    end
  end

  assign drive_o = drive_q;

endmodule

// File: rtl/phase_drive_bank.sv
// Per-channel phase-shifted drive bank with staged configuration applied at cnt == 0.
// PHASE_DRIVE_DUTY_CTRL_EN enables per-channel duty staging and validation.
module phase_drive_bank
  import holo_pkg::*;
#(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned CLK_CNT_W   = DEF_CLK_CNT_W,
  parameter int unsigned CLK_CNT_MAX = DEF_CLK_CNT_MAX,
  localparam int unsigned CHW        = $clog2(NUM_CH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CLK_CNT_W-1:0] cnt,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [CHW-1:0]       wr_ch,
  input  logic [CLK_CNT_W-1:0] wr_phase,
  input  logic                 wr_en,
  input  logic [CLK_CNT_W-1:0] wr_duty,
  input  logic                 commit,
  output logic                 commit_pending,
  output logic                 wr_err,
  output logic [NUM_CH-1:0]    drive
);

  localparam int unsigned DW = CLK_CNT_W + 1;
  localparam logic [DW-1:0] MAX_L = DW'(CLK_CNT_MAX);

  commit_st_e           state_q;
  logic                 wr_err_q;
  logic [NUM_CH-1:0]    stg_en_q;
  logic [CLK_CNT_W-1:0] stg_ph_q [NUM_CH];
`ifdef PHASE_DRIVE_DUTY_CTRL_EN
  logic [CLK_CNT_W-1:0] stg_du_q [NUM_CH];
`else
  logic                 unused_wr_duty;
  assign unused_wr_duty = ^wr_duty;
`endif

  logic wr_fire;
  logic wr_ok;
  logic apply;

  assign wr_ready       = (state_q == ST_IDLE);
  assign commit_pending = (state_q == ST_PENDING);
  assign wr_err         = wr_err_q;
  assign wr_fire        = wr_valid && wr_ready;
  assign apply          = (state_q == ST_PENDING) && (cnt == '0);

  always_comb begin
    wr_ok = (wr_ch < CHW'(NUM_CH)) && ({1'b0, wr_phase} < MAX_L);
`ifdef PHASE_DRIVE_DUTY_CTRL_EN
    wr_ok = wr_ok && ({1'b0, wr_duty} <= MAX_L);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_fire && !wr_ok;
      case (state_q)
        ST_IDLE:    if (commit) state_q <= ST_PENDING;
        ST_PENDING: if (cnt == '0) state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  // Staging only moves while idle, so a same-cycle write joins the commit it accompanies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_en_q <= '0;
      stg_ph_q <= '{default: '0};
`ifdef PHASE_DRIVE_DUTY_CTRL_EN
      stg_du_q <= '{default: CLK_CNT_W'(CLK_CNT_MAX / 2)};
`endif
    end else if (wr_fire && wr_ok) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (wr_ch == CHW'(i)) begin
          stg_en_q[i] <= wr_en;
          stg_ph_q[i] <= wr_phase;
`ifdef PHASE_DRIVE_DUTY_CTRL_EN
          stg_du_q[i] <= wr_duty;
`endif
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    phase_drive_ch #(
      .CLK_CNT_W  (CLK_CNT_W),
      .CLK_CNT_MAX(CLK_CNT_MAX)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .cnt_i  (cnt),
      .apply_i(apply),
      .en_i   (stg_en_q[g]),
      .phase_i(stg_ph_q[g]),
`ifdef PHASE_DRIVE_DUTY_CTRL_EN
      .duty_i (stg_du_q[g]),
`endif
      .drive_o(drive[g])
    );
  end

endmodule
